// File: rtl/bcd_counter_multi.sv
// Multi-digit BCD up/down counter with enable, validated parallel load,
// wrap/saturate boundary handling and a combinational terminal-count output.
module bcd_counter_multi #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  load_err
);

  logic [4*DIGITS-1:0] q_q, q_d;
  logic                load_err_q, load_err_d;

  logic                load_ok;
  logic                is_max;
  logic                is_zero;
  logic                at_boundary;
  logic [4*DIGITS-1:0] step_val;
  logic                carry;
  logic [3:0]          digit;

  always_comb begin
    load_ok = 1'b1;
    is_max  = 1'b1;
    is_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
      if (q_q[4*i +: 4] != 4'd9)     is_max  = 1'b0;
      if (q_q[4*i +: 4] != 4'd0)     is_zero = 1'b0;
    end
  end

  // Ripple the carry/borrow through every digit so the whole count settles in one cycle.
  always_comb begin
    carry    = 1'b1;
    step_val = q_q;
    digit    = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = q_q[4*i +: 4];
      if (carry) begin
        if (up_dn) begin
          if (digit == 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = digit + 4'd1;
            carry              = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = digit - 4'd1;
            carry              = 1'b0;
          end
        end
      end
    end
  end

  assign at_boundary = up_dn ? is_max : is_zero;
  assign tc          = en & ~load & ~rst & at_boundary;

  always_comb begin
    q_d        = q_q;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) q_d        = load_val;
      else         load_err_d = 1'b1;
    end else if (en) begin
      // Saturating mode simply holds at the boundary; wrapping falls out of the ripple.
      if (!(at_boundary && !WRAP)) q_d = step_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q        <= '0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = q_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Self-checking bench: three counter configurations driven in lockstep and
// compared against an integer-valued reference model.
module tb_bcd_counter_multi;

  logic        clk = 1'b0;
  logic        rst, en, up_dn, load;
  logic [11:0] load_val;

  logic [7:0]  q0, q1;
  logic [11:0] q2;
  logic        tc0, tc1, tc2;
  logic        err0, err1, err2;

  int checks = 0;
  int errors = 0;

  int m_val[3];
  bit m_err[3];
  int digs[3]  = '{2, 2, 3};
  bit wraps[3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  bcd_counter_multi #(.DIGITS(2), .WRAP(1'b1)) dut_wrap2 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val[7:0]), .q(q0), .tc(tc0), .load_err(err0));

  bcd_counter_multi #(.DIGITS(2), .WRAP(1'b0)) dut_sat2 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val[7:0]), .q(q1), .tc(tc1), .load_err(err1));

  bcd_counter_multi #(.DIGITS(3), .WRAP(1'b1)) dut_wrap3 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .q(q2), .tc(tc2), .load_err(err2));

  function automatic int max_of(int d);
    int m = 1;
    for (int i = 0; i < d; i++) m = m * 10;
    return m - 1;
  endfunction

  function automatic bit bcd_valid(logic [11:0] v, int d);
    for (int i = 0; i < d; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd_to_int(logic [11:0] v, int d);
    int r = 0;
    for (int i = d - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [11:0] int_to_bcd(int x, int d);
    logic [11:0] r = '0;
    int t = x;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [11:0] dut_q(int k);
    if (k == 0) return {4'h0, q0};
    if (k == 1) return {4'h0, q1};
    return q2;
  endfunction

  function automatic logic dut_tc(int k);
    if (k == 0) return tc0;
    if (k == 1) return tc1;
    return tc2;
  endfunction

  function automatic logic dut_err(int k);
    if (k == 0) return err0;
    if (k == 1) return err1;
    return err2;
  endfunction

  function automatic bit model_tc(int k);
    int mx = max_of(digs[k]);
    return en && !load && !rst && (up_dn ? (m_val[k] == mx) : (m_val[k] == 0));
  endfunction

  task automatic model_edge(int k);
    int mx = max_of(digs[k]);
    if (rst) begin
      m_val[k] = 0;
      m_err[k] = 1'b0;
    end else if (load) begin
      if (bcd_valid(load_val, digs[k])) begin
        m_val[k] = bcd_to_int(load_val, digs[k]);
        m_err[k] = 1'b0;
      end else begin
        m_err[k] = 1'b1;
      end
    end else begin
      m_err[k] = 1'b0;
      if (en) begin
        if (up_dn) m_val[k] = (m_val[k] == mx) ? (wraps[k] ? 0 : mx) : m_val[k] + 1;
        else       m_val[k] = (m_val[k] == 0)  ? (wraps[k] ? mx : 0) : m_val[k] - 1;
      end
    end
  endtask

  task automatic checkOutput(string tag, logic [11:0] actual, logic [11:0] expected);
    checks++;
    assert (actual === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // One clock: drive inputs, check tc before the edge, then q/load_err after it.
  task automatic applyStimulus(bit r, bit e, bit u, bit l, logic [11:0] v);
    @(negedge clk);
    rst = r; en = e; up_dn = u; load = l; load_val = v;
    #1;
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("tc_inst%0d", k), {11'b0, dut_tc(k)}, {11'b0, model_tc(k)});
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k);
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("q_inst%0d", k), dut_q(k), int_to_bcd(m_val[k], digs[k]));
      checkOutput($sformatf("err_inst%0d", k), {11'b0, dut_err(k)}, {11'b0, m_err[k]});
    end
  endtask

  initial begin
    logic [11:0] rv;
    logic [11:0] corners[5];
    corners = '{12'h000, 12'h999, 12'h099, 12'h001, 12'h998};
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
    for (int k = 0; k < 3; k++) begin m_val[k] = 0; m_err[k] = 1'b0; end

    applyStimulus(1, 0, 1, 0, 12'h000);
    applyStimulus(1, 0, 1, 0, 12'h000);
    checkOutput("reset_q", q2, 12'h000);

    for (int c = 0; c < 101; c++) applyStimulus(0, 1, 1, 0, 12'h000);
    checkOutput("up101_wrap", {4'h0, q0}, 12'h001);
    checkOutput("up101_sat",  {4'h0, q1}, 12'h099);
    checkOutput("up101_d3",   q2, 12'h101);

    applyStimulus(0, 0, 0, 1, 12'h010);
    for (int c = 0; c < 12; c++) applyStimulus(0, 1, 0, 0, 12'h000);
    checkOutput("down_wrap", {4'h0, q0}, 12'h098);
    checkOutput("down_sat",  {4'h0, q1}, 12'h000);

    applyStimulus(0, 0, 1, 1, 12'h098);
    for (int c = 0; c < 3; c++) applyStimulus(0, 1, 1, 0, 12'h000);
    checkOutput("sat_up_hold", {4'h0, q1}, 12'h099);
    applyStimulus(0, 0, 0, 1, 12'h001);
    for (int c = 0; c < 3; c++) applyStimulus(0, 1, 0, 0, 12'h000);
    checkOutput("sat_dn_hold", {4'h0, q1}, 12'h000);

    applyStimulus(0, 0, 1, 1, 12'h042);
    applyStimulus(0, 1, 1, 1, 12'h04A);
    checkOutput("bad_load_q",   {4'h0, q0}, 12'h042);
    checkOutput("bad_load_err", {11'b0, err0}, 12'h001);
    applyStimulus(0, 0, 1, 0, 12'h000);
    checkOutput("err_clears", {11'b0, err0}, 12'h000);
    applyStimulus(0, 0, 1, 1, 12'hA57);
    checkOutput("top_nibble_bad", {11'b0, err2}, 12'h001);
    applyStimulus(0, 0, 1, 1, 12'h057);
    checkOutput("good_load", {4'h0, q0}, 12'h057);

    applyStimulus(1, 1, 1, 1, 12'h033);
    checkOutput("rst_priority", {4'h0, q0}, 12'h000);
    applyStimulus(0, 1, 1, 1, 12'h033);
    checkOutput("load_over_en", {4'h0, q0}, 12'h033);
    for (int c = 0; c < 5; c++) applyStimulus(0, 0, 1, 0, 12'h000);
    checkOutput("en_low_hold", {4'h0, q0}, 12'h033);

    applyStimulus(0, 0, 1, 1, 12'h198);
    applyStimulus(0, 1, 1, 0, 12'h000);
    applyStimulus(0, 1, 1, 0, 12'h000);
    checkOutput("d3_carry", q2, 12'h200);
    applyStimulus(0, 1, 0, 0, 12'h000);
    checkOutput("d3_reverse", q2, 12'h199);
    applyStimulus(1, 1, 0, 0, 12'h000);
    checkOutput("mid_reset", q2, 12'h000);

    for (int c = 0; c < 400; c++) begin
      rv = 12'($urandom);
      if ($urandom_range(0, 1) == 0)
        for (int i = 0; i < 3; i++) rv[4*i +: 4] = 4'(rv[4*i +: 4] % 10);
      if ($urandom_range(0, 3) == 0) rv = corners[$urandom_range(0, 4)];
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                    1'($urandom), $urandom_range(0, 7) == 0, rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
